// File: rtl/bist_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bist_led_ctrl
//  Brief    : Start/busy/done LED self-test sequencer with debounced switch
//             override of LED ownership.
//  Revision : 1.0 - initial release
// ============================================================================
module bist_led_ctrl #(
    parameter int TICK_DIV   = 10,
    parameter int DEB_CYCLES = 4,
    parameter int LOOPS      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] sw,
    output logic [3:0] led,
    output logic       busy,
    output logic       done,
    output logic       user_mode
);

    localparam logic [15:0] c_TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  c_DEB       = 8'(DEB_CYCLES);
    localparam logic [7:0]  c_LOOPS     = 8'(LOOPS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_CLEAR = 3'd3;
    localparam logic [2:0] S_USER  = 3'd4;

    logic [3:0]  sw_s1_q, sw_s2_q, sw_s3_q, sw_db_q;
    logic [7:0]  deb_cnt_q, deb_cnt_d;
    logic [2:0]  state_q, state_d;
    logic [3:0]  led_q, led_d;
    logic [15:0] tick_q, tick_d;
    logic [1:0]  step_q, step_d;
    logic [7:0]  loop_q, loop_d;
    logic        done_q, done_d;

    logic        user_req;
    logic        step_evt;
    logic [7:0]  loop_inc;

    // deb_cnt holds the length of the current run of equal synchronised
    // samples, including the sample seen at this edge.
    always_comb begin
        deb_cnt_d = 8'd1;
        if (sw_s2_q == sw_s3_q) begin
            deb_cnt_d = (deb_cnt_q == c_DEB) ? deb_cnt_q : deb_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q   <= 4'b0000;
            sw_s2_q   <= 4'b0000;
            sw_s3_q   <= 4'b0000;
            sw_db_q   <= 4'b0000;
            deb_cnt_q <= 8'd0;
        end else begin
            sw_s1_q   <= sw;
            sw_s2_q   <= sw_s1_q;
            sw_s3_q   <= sw_s2_q;
            deb_cnt_q <= deb_cnt_d;
            if (deb_cnt_d == c_DEB) begin
                sw_db_q <= sw_s2_q;
            end
        end
    end

    assign user_req = |sw_db_q;
    assign step_evt = (tick_q == c_TICK_LAST);
    assign loop_inc = loop_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            led_q   <= 4'b0000;
            tick_q  <= 16'd0;
            step_q  <= 2'd0;
            loop_q  <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        tick_d  = tick_q;
        step_d  = step_q;
        loop_d  = loop_q;
        done_d  = 1'b0;

        // Switch override wins over everything and discards any running test.
        if (user_req && (state_q != S_USER)) begin
            state_d = S_USER;
            led_d   = sw_db_q;
            tick_d  = 16'd0;
            step_d  = 2'd0;
            loop_d  = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    led_d = 4'b0000;
                    if (start) begin
                        state_d = S_FILL;
                        tick_d  = 16'd0;
                        step_d  = 2'd0;
                        loop_d  = 8'd0;
                    end
                end
                S_FILL, S_DRAIN, S_CLEAR: begin
                    tick_d = step_evt ? 16'd0 : tick_q + 16'd1;
                    if (step_evt) begin
                        step_d = step_q + 2'd1;
                        if (state_q == S_FILL) begin
                            led_d = {1'b1, led_q[3:1]};
                            if (step_q == 2'd3) begin
                                state_d = S_DRAIN;
                            end
                        end else if (state_q == S_DRAIN) begin
                            led_d = {led_q[2:0], 1'b0};
                            if (step_q == 2'd3) begin
                                state_d = S_CLEAR;
                            end
                        end else begin
                            step_d = 2'd0;
                            led_d  = 4'b0000;
                            loop_d = loop_inc;
                            if ((c_LOOPS != 8'd0) && (loop_inc == c_LOOPS)) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_FILL;
                            end
                        end
                    end
                end
                S_USER: begin
                    if (user_req) begin
                        led_d = sw_db_q;
                    end else begin
                        state_d = S_IDLE;
                        led_d   = 4'b0000;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    led_d   = 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        led       = led_q;
        done      = done_q;
        busy      = (state_q == S_FILL) || (state_q == S_DRAIN) || (state_q == S_CLEAR);
        user_mode = (state_q == S_USER);
    end

endmodule
`default_nettype wire

// File: tb/tb_bist_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bist_led_ctrl
//  Brief    : Directed self-checking bench for bist_led_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bist_led_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b, start_c;
    logic [3:0] sw_a, sw_b, sw_c;
    logic [3:0] led_a, led_b, led_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic       user_a, user_b, user_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bist_led_ctrl #(.TICK_DIV(10), .DEB_CYCLES(4), .LOOPS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sw(sw_a),
        .led(led_a), .busy(busy_a), .done(done_a), .user_mode(user_a)
    );

    bist_led_ctrl #(.TICK_DIV(1), .DEB_CYCLES(4), .LOOPS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sw(sw_b),
        .led(led_b), .busy(busy_b), .done(done_b), .user_mode(user_b)
    );

    bist_led_ctrl #(.TICK_DIV(2), .DEB_CYCLES(4), .LOOPS(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .sw(sw_c),
        .led(led_c), .busy(busy_c), .done(done_c), .user_mode(user_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        sw_a    = 4'b0; sw_b    = 4'b0; sw_c    = 4'b0;
        #3;
        n_vec++;
        if ({led_a, busy_a, done_a, user_a} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_a: got %b expected 0000000", {led_a, busy_a, done_a, user_a});
        end
        n_vec++;
        if ({led_b, busy_b, done_b, user_b, led_c, busy_c, done_c, user_c} !== 14'b0) begin
            n_err++;
            $display("FAIL reset_bc: got %b expected 0", {led_b, busy_b, done_b, user_b, led_c, busy_c, done_c, user_c});
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if ({led_a, busy_a, done_a, user_a} !== 7'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b expected 0000000", {led_a, busy_a, done_a, user_a});
        end
    endtask

    task automatic test_basic_pattern();
        logic [3:0] exp_led [0:8];
        int dones;
        exp_led = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
        dones = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_vec++;
        if (busy_a !== 1'b1 || led_a !== 4'b0000) begin
            n_err++;
            $display("FAIL basic_e0: busy=%b led=%b expected busy=1 led=0000", busy_a, led_a);
        end
        for (int t = 1; t <= 90; t++) begin
            tick();
            if (done_a === 1'b1) dones++;
            if (t % 10 == 0) begin
                n_vec++;
                if (led_a !== exp_led[t/10 - 1]) begin
                    n_err++;
                    $display("FAIL basic_led_t%0d: got %b expected %b", t, led_a, exp_led[t/10 - 1]);
                end
            end
        end
        n_vec++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: done=%b busy=%b expected done=1 busy=0", done_a, busy_a);
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL basic_done_count: got %0d expected 1", dones);
        end
        tick();
        n_vec++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL basic_after_done: done=%b busy=%b expected 0 0", done_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        start_b = 1'b1;
        tick();
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (done_b === 1'b1) dones++;
        end
        n_vec++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || led_b !== 4'b0000) begin
            n_err++;
            $display("FAIL b2b_done: done=%b busy=%b led=%b expected 1 0 0000", done_b, busy_b, led_b);
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL b2b_done_count: got %0d expected 1", dones);
        end
        tick();
        n_vec++;
        if (busy_b !== 1'b1 || done_b !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_restart: busy=%b done=%b expected 1 0", busy_b, done_b);
        end
        start_b = 1'b0;
    endtask

    task automatic test_glitch();
        logic [3:0] exp_led [0:8];
        int dones, users;
        exp_led = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
        dones = 0;
        users = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int t = 1; t <= 90; t++) begin
            tick();
            if (t == 12) sw_a = 4'b0010;
            if (t == 15) sw_a = 4'b0000;
            if (done_a === 1'b1) dones++;
            if (user_a !== 1'b0) users++;
            if (t % 10 == 0) begin
                n_vec++;
                if (led_a !== exp_led[t/10 - 1]) begin
                    n_err++;
                    $display("FAIL glitch_led_t%0d: got %b expected %b", t, led_a, exp_led[t/10 - 1]);
                end
            end
        end
        n_vec++;
        if (dones !== 1 || users !== 0 || done_a !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_outcome: dones=%0d user_cycles=%0d done=%b expected 1 0 1", dones, users, done_a);
        end
        tick();
    endtask

    task automatic test_user_override();
        int dones, drops;
        dones = 0;
        drops = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int t = 1; t <= 55; t++) tick();
        n_vec++;
        if (led_a !== 4'b1110 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_middrain: led=%b busy=%b expected 1110 1", led_a, busy_a);
        end
        sw_a = 4'b0101;
        for (int i = 0; i < 6; i++) tick();
        n_vec++;
        if (user_a !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_early: user_mode=%b expected 0", user_a);
        end
        tick();
        n_vec++;
        if (user_a !== 1'b1 || led_a !== 4'b0101 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_entry: user=%b led=%b busy=%b expected 1 0101 0", user_a, led_a, busy_a);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done_a === 1'b1) dones++;
            if (user_a !== 1'b1 || led_a !== 4'b0101) drops++;
        end
        n_vec++;
        if (dones !== 0 || drops !== 0) begin
            n_err++;
            $display("FAIL ovr_hold: dones=%0d drops=%0d expected 0 0", dones, drops);
        end
        sw_a = 4'b0000;
        for (int i = 0; i < 6; i++) tick();
        n_vec++;
        if (user_a !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_exit_early: user_mode=%b expected 1", user_a);
        end
        tick();
        n_vec++;
        if (user_a !== 1'b0 || led_a !== 4'b0000 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_exit: user=%b led=%b busy=%b expected 0 0000 0", user_a, led_a, busy_a);
        end
        for (int i = 0; i < 20; i++) tick();
        n_vec++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || led_a !== 4'b0000) begin
            n_err++;
            $display("FAIL ovr_stays_idle: busy=%b done=%b led=%b expected 0 0 0000", busy_a, done_a, led_a);
        end
    endtask

    task automatic test_loops_forever();
        int dones, idle_cycles;
        dones = 0;
        idle_cycles = 0;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (done_c === 1'b1) dones++;
            if (busy_c !== 1'b1) idle_cycles++;
            if (t == 92) begin
                n_vec++;
                if (led_c !== 4'b1000) begin
                    n_err++;
                    $display("FAIL forever_led_loop6: got %b expected 1000", led_c);
                end
            end
        end
        n_vec++;
        if (dones !== 0 || idle_cycles !== 0) begin
            n_err++;
            $display("FAIL forever_running: dones=%0d idle_cycles=%0d expected 0 0", dones, idle_cycles);
        end
        sw_c = 4'b1111;
        for (int i = 0; i < 7; i++) tick();
        n_vec++;
        if (user_c !== 1'b1 || led_c !== 4'b1111 || busy_c !== 1'b0 || done_c !== 1'b0) begin
            n_err++;
            $display("FAIL forever_override: user=%b led=%b busy=%b done=%b expected 1 1111 0 0", user_c, led_c, busy_c, done_c);
        end
        sw_c = 4'b0000;
        for (int i = 0; i < 7; i++) tick();
        n_vec++;
        if (user_c !== 1'b0 || led_c !== 4'b0000 || busy_c !== 1'b0) begin
            n_err++;
            $display("FAIL forever_exit: user=%b led=%b busy=%b expected 0 0000 0", user_c, led_c, busy_c);
        end
    endtask

    task automatic test_reset_mid_fill();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int t = 1; t <= 25; t++) tick();
        n_vec++;
        if (led_a !== 4'b1100 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL rstfill_pre: led=%b busy=%b expected 1100 1", led_a, busy_a);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({led_a, busy_a, done_a, user_a} !== 7'b0) begin
            n_err++;
            $display("FAIL rstfill_async: got %b expected 0000000", {led_a, busy_a, done_a, user_a});
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        n_vec++;
        if (led_a !== 4'b0000 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL rstfill_idle: led=%b busy=%b done=%b expected 0000 0 0", led_a, busy_a, done_a);
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int t = 1; t <= 10; t++) tick();
        n_vec++;
        if (busy_a !== 1'b1 || led_a !== 4'b1000) begin
            n_err++;
            $display("FAIL rstfill_rerun: busy=%b led=%b expected 1 1000", busy_a, led_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pattern();
        test_back_to_back();
        test_glitch();
        test_user_override();
        test_loops_forever();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bist_led_ctrl.md
# bist_led_ctrl

Sequencing controller for the board's switch/LED self-test. On a start request it drives a timed fill/drain walking pattern on the 4 LEDs for a programmable number of loops and then reports completion. It hands LED ownership to the switches whenever the user sets any debounced switch. It sits between the top-level `clk`/`sw` pins and the `led` pins and replaces free-running pattern logic with a start/busy/done-controlled test.

## Interface

- `TICK_DIV`, 10: clk cycles per pattern step; legal range 1..2^16-1.
- `DEB_CYCLES`, 4: consecutive identical switch samples required before the debounced value updates; legal range 1..255.
- `LOOPS`, 2: full pattern loops per test; legal range 0..255; 0 means run until override or reset.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: test request, sampled each edge; used only in IDLE.
- `sw`, in, 4: raw switch inputs, asynchronous to the design; double-flop synchronised internally.
- `led`, out, 4: LED drive, registered.
- `busy`, out, 1: high in FILL, DRAIN and CLEAR.
- `done`, out, 1: one-cycle pulse on normal test completion.
- `user_mode`, out, 1: high while the switches own the LEDs (USER state).

## Operation

- Reset value of all outputs and state is 0: `led`=0000, `busy`=0, `done`=0, `user_mode`=0, state IDLE. The debounced value `sw_db`, tick counter and loop counter are also 0.
- Debounce:
  - Synchronised `sw` is compared with its previous sample. Any difference clears the stability counter.
  - After `DEB_CYCLES` consecutive equal samples, `sw_db` takes that value.
  - `user_req` = (`sw_db` != 0).
- FSM states are IDLE, FILL, DRAIN, CLEAR and USER. Priority order at every edge is `user_req` > sequence > `start`.
- IDLE: `led`=0000. `user_req` moves to USER. Otherwise `start`=1 moves to FILL, clears the tick and loop counters, and sets `busy`.
- Tick counter runs only in FILL, DRAIN and CLEAR. It counts 0..`TICK_DIV`-1, and a step occurs at the edge where it equals `TICK_DIV`-1; the counter then wraps to 0.
- FILL: each step sets `led` <= {1, led[3:1]}, giving 1000, 1100, 1110, 1111. After the 4th step it moves to DRAIN.
- DRAIN: each step sets `led` <= {led[2:0], 0}, giving 1110, 1100, 1000, 0000. After the 4th step it moves to CLEAR.
- CLEAR: holds 0000 for one step, then the loop counter increments.
  - If `LOOPS`!=0 and the count equals `LOOPS`: go to IDLE, pulse `done`, drop `busy`.
  - Otherwise: go back to FILL.
- A loop is therefore 9 steps.
- USER: `led` <= `sw_db` every cycle and `user_mode`=1. When `sw_db` returns to 0000, go to IDLE with `led`=0000.
- An override from FILL, DRAIN or CLEAR aborts the test. No `done` is produced and the loop count is discarded; a new `start` is required afterwards.
- `start` is ignored while `busy` is high or in USER. It is level-sampled, so holding it high in IDLE retriggers immediately after `done`.

## Timing

- Let E0 be the edge at which `start` is accepted. `busy`=1 from E0.
- Step k (k≥1) is applied at edge E0 + k·`TICK_DIV`.
- For `LOOPS`=L≥1: at edge E0 + 9·L·`TICK_DIV`:
  - `done`=1 for exactly one cycle;
  - `busy`=0 on the same edge;
  - `led`=0000.
- Raw `sw` change to `sw_db` update takes 2 sync edges + `DEB_CYCLES` edges, provided `sw` is stable throughout.
- `sw_db` update to state/`led` change takes 1 edge, both for USER entry and USER exit.
- `rst_n` low at any time, including mid-step or in USER: all outputs are 0 immediately (asynchronously). No `done` pulse is produced.

## Test plan

- Reset, then `start` pulse with TICK_DIV=10, LOOPS=1, sw=0:
  - `led` is 1000 @E0+10, 1100 @+20, 1110 @+30, 1111 @+40, 1110 @+50, 1100 @+60, 1000 @+70, 0000 @+80;
  - `done` pulses @+90 and `busy` falls the same edge.
- LOOPS=2, TICK_DIV=1: exactly one `done` pulse, 18 cycles after E0. `start` held high thereafter causes a restart on the following edge.
- Mid-DRAIN, set sw=0101 and hold: `user_mode`=1 and `led`=0101 at 2+`DEB_CYCLES`+1 edges after the change. No `done`. Then sw=0000: return to IDLE with `led`=0000.
- sw glitch to 0010 lasting `DEB_CYCLES`-1 cycles: `sw_db` stays 0000 and the pattern continues unperturbed.
- Assert `rst_n`=0 mid-FILL (`led`=1100): `led`/`busy`/`done` = 0 immediately. After release, state is IDLE, and `start` is needed to run.
- LOOPS=0: pattern repeats for ≥5 loops with no `done`. It stops only on sw override.
